wb_select_pipe: RTL and testbench

- Parametrised successor to the register-file write-data selector: picks one of NUM_SRC WIDTH-bit sources and registers the result.
- Sources include ALUOut, LO, HI, LTSignExtend, ShiftLeft4, ShiftRegOut and SetSizeOut.
- Output is buffered through a 2-entry skid buffer with valid/ready handshakes, so write-back can stall without dropping results.
- Carries the destination register index alongside the data, flags illegal selects, and can suppress writes of nonzero data to register 0.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_src_mux.sv | 22 ++
 rtl/wb_select_pipe.sv | 105 ++++++++++
 tb/tb_wb_select_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared state encodings, default widths and legacy source indices for the write-back selector
package wb_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} wb_state_t;
   localparam int WB_WIDTH  = 32;
   localparam int WB_ADDR_W = 5;
   localparam int ALUOUT    = 0;
   localparam int LO        = 1;
   localparam int HI        = 2;
   localparam int LTSIGNEXT = 3;
   localparam int SHIFTL4   = 4;
   localparam int SHIFTREG  = 5;
   localparam int SRC_RSVD  = 6;
   localparam int SETSIZE   = 7;
endpackage

// File: rtl/wb_src_mux.sv
// wb_src_mux: combinational NUM_SRC:1 selector, zero output and illegal flag when sel >= NUM_SRC
//   sel      - source index
//   src_data - flattened sources, source 0 in the LSBs
//   data     - selected source (0 when illegal)
//   illegal  - sel is out of range
module wb_src_mux #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 8,
   parameter int SEL_W   = 3
) (
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   output logic [WIDTH-1:0]         data,
   output logic                     illegal
);
   always_comb begin
      illegal = int'(sel) >= NUM_SRC;
      data = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (sel == SEL_W'(i)) data = src_data[i*WIDTH +: WIDTH];
   end
endmodule

// File: rtl/wb_select_pipe.sv
// wb_select_pipe: register-file write-data selector with a 2-entry skid buffer on the output
//   clk/reset            - clock, synchronous active-high reset
//   in_valid/in_ready    - upstream handshake; in_ready depends only on buffer state
//   sel/src_data/in_dest - source select, flattened sources, destination index
//   out_valid/out_ready  - downstream handshake
//   out_data/out_dest    - head entry, held stable while stalled
//   sel_err/sel_err_clr  - sticky illegal-select flag and its clear (set wins)
//   xfer_cnt             - wrapping count of output transfers
module wb_select_pipe
   import wb_pkg::*;
#(
   parameter int WIDTH         = WB_WIDTH,
   parameter int NUM_SRC       = 8,
   parameter int SEL_W         = 3,
   parameter int ADDR_W        = WB_ADDR_W,
   parameter int ZERO_SUPPRESS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [ADDR_W-1:0]        in_dest,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [ADDR_W-1:0]        out_dest,
   output logic                     sel_err,
   input  logic                     sel_err_clr,
   output logic [15:0]              xfer_cnt
);
   if (NUM_SRC < 2 || NUM_SRC > 16 || (1 << SEL_W) < NUM_SRC) begin : g_bad_cfg
      $error("wb_select_pipe: NUM_SRC must be 2..16 and fit in SEL_W bits");
   end

   wb_state_t state_q, state_d;
   logic [WIDTH-1:0] mux_data, new_data, skid_data;
   logic [ADDR_W-1:0] skid_dest;
   logic illegal, in_xfer, out_xfer, load_main, load_skid, skid_to_main;

   wb_src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux (
      .sel(sel),
      .src_data(src_data),
      .data(mux_data),
      .illegal(illegal)
   );

   // Writes to register 0 carry zero data so a downstream port without its own guard stays safe
   assign new_data  = (ZERO_SUPPRESS != 0 && in_dest == '0) ? '0 : mux_data;
   assign in_ready  = !reset && state_q != FULL;
   assign out_valid = state_q != EMPTY;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      skid_to_main = 1'b0;
      case (state_q)
         EMPTY: begin
            load_main = in_xfer;
            state_d = in_xfer ? ONE : EMPTY;
         end
         ONE: begin
            load_main = in_xfer && out_xfer;
            load_skid = in_xfer && !out_xfer;
            state_d = load_skid ? FULL : (out_xfer && !in_xfer) ? EMPTY : ONE;
         end
         FULL: begin
            skid_to_main = out_xfer;
            state_d = out_xfer ? ONE : FULL;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= EMPTY;
         out_data  <= '0;
         out_dest  <= '0;
         skid_data <= '0;
         skid_dest <= '0;
         sel_err   <= 1'b0;
         xfer_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (load_main) begin
            out_data <= new_data;
            out_dest <= in_dest;
         end else if (skid_to_main) begin
            out_data <= skid_data;
            out_dest <= skid_dest;
         end
         if (load_skid) begin
            skid_data <= new_data;
            skid_dest <= in_dest;
         end
         sel_err <= (in_xfer && illegal) || (sel_err && !sel_err_clr);
         if (out_xfer) xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_wb_select_pipe.sv
// tb_wb_select_pipe: directed and scoreboarded checks of wb_select_pipe in three configurations
module tb_wb_select_pipe;
   logic clk = 1'b0;
   logic reset, in_valid, out_ready, sel_err_clr;
   logic [2:0] sel;
   logic [255:0] src_data;
   logic [4:0] in_dest;
   logic a_in_ready, a_out_valid, a_sel_err;
   logic [31:0] a_out_data;
   logic [4:0] a_out_dest;
   logic [15:0] a_xfer;
   logic s_in_ready, s_out_valid, s_sel_err;
   logic [31:0] s_out_data;
   logic [4:0] s_out_dest;
   logic [15:0] s_xfer;
   logic n_in_ready, n_out_valid, n_sel_err;
   logic [31:0] n_out_data;
   logic [4:0] n_out_dest;
   logic [15:0] n_xfer;
   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {logic [31:0] data; logic [4:0] dest;} ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   wb_select_pipe u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .sel(sel),
      .src_data(src_data), .in_dest(in_dest), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_dest(a_out_dest), .sel_err(a_sel_err),
      .sel_err_clr(sel_err_clr), .xfer_cnt(a_xfer)
   );

   wb_select_pipe #(.NUM_SRC(6)) u_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .sel(sel),
      .src_data(src_data[191:0]), .in_dest(in_dest), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_dest(s_out_dest), .sel_err(s_sel_err),
      .sel_err_clr(sel_err_clr), .xfer_cnt(s_xfer)
   );

   wb_select_pipe #(.ZERO_SUPPRESS(0)) u_n (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .sel(sel),
      .src_data(src_data), .in_dest(in_dest), .out_valid(n_out_valid), .out_ready(out_ready),
      .out_data(n_out_data), .out_dest(n_out_dest), .sel_err(n_sel_err),
      .sel_err_clr(sel_err_clr), .xfer_cnt(n_xfer)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL timeout simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      logic in_acc, out_acc;
      logic [15:0] mcnt;
      ent_t e;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel_err_clr = 1'b0;
      sel = '0; src_data = '0; in_dest = '0;
      step();
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data", a_out_data, 32'd0);
      chk("rst_out_dest", 32'(a_out_dest), 32'd0);
      chk("rst_sel_err", 32'(a_sel_err), 32'd0);
      chk("rst_xfer", 32'(a_xfer), 32'd0);
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

      // legacy walk: source i carries i+1
      for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = 32'(i + 1);
      out_ready = 1'b1; in_valid = 1'b1; in_dest = 5'd1;
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         step();
         chk("walk_data", a_out_data, 32'(k + 1));
         chk("walk_dest", 32'(a_out_dest), 32'd1);
      end
      chk("six_illegal_data", s_out_data, 32'd0);
      in_valid = 1'b0;
      step();
      chk("walk_drained", 32'(a_out_valid), 32'd0);
      chk("walk_xfer", 32'(a_xfer), 32'd8);
      chk("walk_six_sel_err", 32'(s_sel_err), 32'd1);
      chk("walk_main_sel_err", 32'(a_sel_err), 32'd0);

      // sticky flag: plain clear, then clear coincident with a new illegal select
      sel_err_clr = 1'b1;
      step();
      chk("clr_sel_err", 32'(s_sel_err), 32'd0);
      in_valid = 1'b1; sel = 3'd7;
      step();
      chk("set_wins", 32'(s_sel_err), 32'd1);
      chk("set_wins_data", s_out_data, 32'd0);
      chk("main_sel7", a_out_data, 32'd8);
      in_valid = 1'b0; sel_err_clr = 1'b0;
      step();
      chk("sticky", 32'(s_sel_err), 32'd1);
      chk("xfer_9", 32'(a_xfer), 32'd9);

      // backpressure
      out_ready = 1'b0; sel = 3'd0; in_dest = 5'd2; src_data[31:0] = 32'h11; in_valid = 1'b1;
      step();
      chk("bp_ready_one", 32'(a_in_ready), 32'd1);
      chk("bp_data_a", a_out_data, 32'h11);
      src_data[31:0] = 32'h22;
      step();
      chk("bp_ready_full", 32'(a_in_ready), 32'd0);
      chk("bp_hold", a_out_data, 32'h11);
      src_data[31:0] = 32'h33;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold", a_out_data, 32'h11);
         chk("bp_hold_dest", 32'(a_out_dest), 32'd2);
         chk("bp_stall_ready", 32'(a_in_ready), 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_data_b", a_out_data, 32'h22);
      chk("bp_ready_back", 32'(a_in_ready), 32'd1);
      step();
      chk("bp_empty", 32'(a_out_valid), 32'd0);
      chk("bp_xfer", 32'(a_xfer), 32'd11);

      // register-0 suppression, then reset while FULL
      out_ready = 1'b0; sel = 3'd0; src_data[31:0] = 32'hDEADBEEF; in_dest = 5'd0; in_valid = 1'b1;
      step();
      chk("zs_data", a_out_data, 32'd0);
      chk("zs_dest", 32'(a_out_dest), 32'd0);
      chk("nzs_data", n_out_data, 32'hDEADBEEF);
      sel = 3'd1; src_data[63:32] = 32'h2; in_dest = 5'd3;
      step();
      chk("pre_rst_full", 32'(a_in_ready), 32'd0);
      in_valid = 1'b0; reset = 1'b1;
      step();
      chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_xfer", 32'(a_xfer), 32'd0);
      chk("mid_rst_ready", 32'(a_in_ready), 32'd0);
      chk("mid_rst_data", a_out_data, 32'd0);
      chk("mid_rst_sel_err", 32'(s_sel_err), 32'd0);
      reset = 1'b0;
      step();
      chk("after_rst_ready", 32'(a_in_ready), 32'd1);
      chk("after_rst_valid", 32'(a_out_valid), 32'd0);
      sel = 3'd0; src_data[31:0] = 32'h55; in_dest = 5'd4; in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("fresh_data", a_out_data, 32'h55);
      chk("fresh_dest", 32'(a_out_dest), 32'd4);
      in_valid = 1'b0;
      step();
      chk("fresh_alone", 32'(a_out_valid), 32'd0);
      chk("fresh_xfer", 32'(a_xfer), 32'd1);

      // random streams against a queue model
      mcnt = 16'd1;
      for (int c = 0; c < 300; c++) begin
         in_valid = 1'($urandom);
         out_ready = 1'($urandom);
         sel = 3'($urandom);
         in_dest = 5'($urandom_range(0, 3));
         for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = $urandom;
         chk("rnd_in_ready", 32'(a_in_ready), 32'(q.size() < 2));
         chk("rnd_out_valid", 32'(a_out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("rnd_data", a_out_data, q[0].data);
            chk("rnd_dest", 32'(a_out_dest), 32'(q[0].dest));
         end
         in_acc = in_valid && q.size() < 2;
         out_acc = out_ready && q.size() != 0;
         e.data = (in_dest == 5'd0) ? 32'd0 : src_data[32*int'(sel) +: 32];
         e.dest = in_dest;
         step();
         if (out_acc) begin
            void'(q.pop_front());
            mcnt = mcnt + 16'd1;
         end
         if (in_acc) q.push_back(e);
      end
      chk("rnd_xfer", 32'(a_xfer), 32'(mcnt));

      // counter wrap
      in_valid = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_dest = 5'd1;
      step();
      for (int c = 0; c < 65535; c++) step();
      chk("wrap_ffff", 32'(a_xfer), 32'hFFFF);
      step();
      chk("wrap_0", 32'(a_xfer), 32'd0);
      step();
      chk("wrap_1", 32'(a_xfer), 32'd1);
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
